// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control sequencer for the 16-bit CPU datapath
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [15:0]      Instr2ctrl,
    input  logic             MemReady,
    output logic             Branch,
    output logic             JumpControl,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       WriteControl,
    output logic [1:0]       ALUOperation,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       WndSelect,
    output logic             PCWrite,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] RetireCount,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_next;
    logic [15:0]      ir;
    logic [3:0]       opcode;
    logic [1:0]       wnd;
    logic [CNT_W-1:0] retire_cnt;
    logic             fault;
    logic [TW-1:0]    tmo_cnt;
    logic             retire;
    logic             tmo_hit;
    logic             is_load, is_store, is_halt;
    logic             unused_ir_bits;

    assign opcode   = ir[15:12];
    assign is_load  = (opcode == 4'b0000);
    assign is_store = (opcode == 4'b0001);
    assign is_halt  = (opcode == 4'b0011);

    // Operand fields are consumed by the datapath straight from the instruction bus.
    assign unused_ir_bits = ^ir[11:2];

    always_comb begin
        state_next   = state;
        Branch       = 1'b0;
        JumpControl  = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        WriteControl = 2'b00;
        ALUOperation = 2'b00;
        ALUSrc       = 1'b0;
        RegWrite     = 1'b0;
        PCWrite      = 1'b0;
        retire       = 1'b0;
        tmo_hit      = 1'b0;
        case (state)
            FETCH: state_next = DECODE;
            DECODE: begin
                if (is_load || is_store) state_next = MEM;
                else if (is_halt)        state_next = HALT;
                else                     state_next = EXEC;
            end
            EXEC: begin
                PCWrite    = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
                casez (opcode)
                    4'b0010: JumpControl = 1'b1;
                    4'b0100: begin
                        Branch       = 1'b1;
                        ALUOperation = 2'b01;
                    end
                    4'b1000: begin
                        ALUOperation = ir[1:0];
                        WriteControl = 2'b01;
                        RegWrite     = 1'b1;
                    end
                    4'b1001: begin
                        WriteControl = 2'b10;
                        RegWrite     = 1'b1;
                    end
                    4'b1010: begin
                        WriteControl = 2'b11;
                        RegWrite     = 1'b1;
                    end
                    4'b11??: begin
                        ALUOperation = ir[13:12];
                        ALUSrc       = 1'b1;
                        WriteControl = 2'b01;
                        RegWrite     = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                if (MemReady) begin
                    RegWrite   = is_load;
                    PCWrite    = 1'b1;
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
                    // Last strobed cycle: the counter reaches MEM_TIMEOUT at this edge.
                    tmo_hit    = 1'b1;
                    state_next = HALT;
                end
            end
            HALT: state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= FETCH;
            ir         <= '0;
            wnd        <= 2'b00;
            retire_cnt <= '0;
            fault      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH) ir <= Instr2ctrl;
            if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
            if (tmo_hit) fault <= 1'b1;
            if (state == DECODE)
                tmo_cnt <= '0;
            else if (state == MEM && !MemReady)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (state == EXEC && opcode == 4'b1011) wnd <= ir[1:0];
        end
    end

    assign WndSelect   = wnd;
    assign RetireCount = retire_cnt;
    assign Fault       = fault;
    assign Halted      = (state == HALT);
    assign State       = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic [15:0]      Instr2ctrl = '0;
    logic             MemReady = 1'b0;
    logic             Branch, JumpControl, MemRead, MemWrite;
    logic [1:0]       WriteControl, ALUOperation, WndSelect;
    logic             ALUSrc, RegWrite, PCWrite, Halted, Fault;
    logic [CNT_W-1:0] RetireCount;
    logic [2:0]       State;

    cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Instr2ctrl(Instr2ctrl), .MemReady(MemReady),
        .Branch(Branch), .JumpControl(JumpControl), .MemRead(MemRead),
        .MemWrite(MemWrite), .WriteControl(WriteControl), .ALUOperation(ALUOperation),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .WndSelect(WndSelect), .PCWrite(PCWrite),
        .Halted(Halted), .Fault(Fault), .RetireCount(RetireCount), .State(State)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] ins;
        int          delay;
        logic [10:0] exp;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_retire;
    logic [1:0]  exp_wnd;
    logic        exp_fault;
    vec_t        tbl[$];

    wire [10:0] ctl_now = {Branch, JumpControl, MemRead, MemWrite, WriteControl,
                           ALUOperation, ALUSrc, RegWrite, PCWrite};

    function automatic logic [10:0] ctl(input logic b, j, mr, mw,
                                        input logic [1:0] wc, op,
                                        input logic src, rw, pw);
        return {b, j, mr, mw, wc, op, src, rw, pw};
    endfunction

    // Expected EXEC-cycle controls straight from the opcode table.
    function automatic logic [10:0] exec_ref(input logic [15:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        if (op[3:2] == 2'b11) return ctl(0, 0, 0, 0, 2'b01, ins[13:12], 1, 1, 1);
        case (op)
            4'h2:    return ctl(0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
            4'h4:    return ctl(1, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1);
            4'h8:    return ctl(0, 0, 0, 0, 2'b01, ins[1:0], 0, 1, 1);
            4'h9:    return ctl(0, 0, 0, 0, 2'b10, 2'b00, 0, 1, 1);
            4'hA:    return ctl(0, 0, 0, 0, 2'b11, 2'b00, 0, 1, 1);
            default: return ctl(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input int st);
        chk({tag, ".state"},  32'(State), 32'(st));
        chk({tag, ".ctl"},    32'(ctl_now), 32'd0);
        chk({tag, ".halted"}, 32'(Halted), 32'(st == 4));
        chk({tag, ".fault"},  32'(Fault), 32'(exp_fault));
        chk({tag, ".retire"}, 32'(RetireCount), 32'(exp_retire % (1 << CNT_W)));
        chk({tag, ".wnd"},    32'(WndSelect), 32'(exp_wnd));
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        MemReady = 1'($urandom);
        @(negedge Clk);
        Rst = 1'b1;
        exp_retire = 0;
        exp_wnd    = 2'b00;
        exp_fault  = 1'b0;
        #1 check_idle("reset", 0);
    endtask

    // Drives one instruction from FETCH; delay = MemReady-low cycles before the ready cycle.
    task automatic run_instr(input logic [15:0] ins, input int delay,
                             input logic [10:0] exp, input bit noise);
        logic [3:0] op;
        bit is_load, ready, done;
        op = ins[15:12];
        is_load = (op == 4'h0);
        done = 0;
        Instr2ctrl = ins;
        MemReady = noise ? 1'($urandom) : 1'b0;
        #1 check_idle("fetch", 0);
        @(negedge Clk);
        Instr2ctrl = noise ? 16'($urandom) : ins;
        MemReady = noise ? 1'($urandom) : 1'b0;
        #1 check_idle("decode", 1);
        @(negedge Clk);
        if (op == 4'h3) begin
            MemReady = noise ? 1'($urandom) : 1'b0;
            #1 check_idle("halt_op", 4);
        end else if (op <= 4'h1) begin
            for (int i = 0; i < MEM_TIMEOUT; i++) begin
                ready = (i == delay);
                MemReady = ready;
                #1;
                chk("mem.state", 32'(State), 32'd3);
                chk("mem.ctl", 32'(ctl_now),
                    32'(ctl(0, 0, is_load, !is_load, 2'b00, 2'b00, 0, is_load && ready, ready)));
                @(negedge Clk);
                MemReady = 1'b0;
                if (ready) begin
                    exp_retire++;
                    done = 1;
                    break;
                end
            end
            if (!done) begin
                exp_fault = 1'b1;
                #1 check_idle("timeout", 4);
            end
        end else begin
            MemReady = noise ? 1'($urandom) : 1'b0;
            #1;
            chk("exec.state", 32'(State), 32'd2);
            chk("exec.ctl", 32'(ctl_now), 32'(exp));
            chk("exec.wnd", 32'(WndSelect), 32'(exp_wnd));
            exp_retire++;
            if (op == 4'hB) exp_wnd = ins[1:0];
            @(negedge Clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{16'hC005, 0, ctl(0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 1)});
        tbl.push_back('{16'h0000, 3, 11'd0});
        tbl.push_back('{16'h1000, 0, 11'd0});
        tbl.push_back('{16'hB002, 0, ctl(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1)});
        tbl.push_back('{16'h4000, 0, ctl(1, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1)});
        tbl.push_back('{16'h8003, 0, ctl(0, 0, 0, 0, 2'b01, 2'b11, 0, 1, 1)});
        tbl.push_back('{16'h9000, 0, ctl(0, 0, 0, 0, 2'b10, 2'b00, 0, 1, 1)});
        tbl.push_back('{16'hA000, 0, ctl(0, 0, 0, 0, 2'b11, 2'b00, 0, 1, 1)});
        tbl.push_back('{16'h2155, 0, ctl(0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1)});
        tbl.push_back('{16'h7000, 0, ctl(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1)});
        tbl.push_back('{16'h5000, 0, ctl(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1)});
        tbl.push_back('{16'hE000, 0, ctl(0, 0, 0, 0, 2'b01, 2'b10, 1, 1, 1)});
        tbl.push_back('{16'hD7FF, 0, ctl(0, 0, 0, 0, 2'b01, 2'b01, 1, 1, 1)});
        tbl.push_back('{16'h0ABC, 1, 11'd0});
        tbl.push_back('{16'hB001, 0, ctl(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1)});
        tbl.push_back('{16'h1FFF, 15, 11'd0});

        repeat (2) @(negedge Clk);
        do_reset();

        foreach (tbl[k]) run_instr(tbl[k].ins, tbl[k].delay, tbl[k].exp, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            logic [3:0]  op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'h3) op = 4'h7;
            ins = {op, 12'($urandom)};
            run_instr(ins, $urandom_range(0, 6), exec_ref(ins), 1'b1);
        end

        // STORE that never completes: timeout, sticky fault, HALT holds until reset.
        run_instr(16'h1234, 1000, 11'd0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            MemReady = 1'($urandom);
            Instr2ctrl = 16'($urandom);
            @(negedge Clk);
            #1 check_idle("halt_hold", 4);
        end
        do_reset();

        // HALT opcode, then reset clears window and counter.
        run_instr(16'hB003, 0, exec_ref(16'hB003), 1'b0);
        run_instr(16'h3ABC, 0, 11'd0, 1'b0);
        @(negedge Clk);
        #1 check_idle("halt_op_hold", 4);
        do_reset();

        // Reset while a LOAD is waiting in MEM.
        Instr2ctrl = 16'h0000;
        MemReady = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_mem.state", 32'(State), 32'd3);
        chk("rst_mem.memread", 32'(MemRead), 32'd1);
        do_reset();
        run_instr(16'hC005, 0, exec_ref(16'hC005), 1'b0);
        #1 check_idle("final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit CPU datapath. It latches the instruction word, decodes it, and drives the datapath control lines (Branch, JumpControl, MemRead, MemWrite, WriteControl, ALUOperation, ALUSrc, RegWrite, WndSelect) one state at a time. It gates PC update through PCWrite and waits on a variable-latency data memory (MemReady). It also owns the register-window pointer, a retired-instruction counter, and halt/fault status.

Parameters:
MEM_TIMEOUT, 16, max cycles waited in MEM for MemReady before Fault.
CNT_W, 16, width of RetireCount.

Ports:
Clk  input  1  clock, rising edge.
Rst  input  1  reset, synchronous, active-low; Clk is the clock.
Instr2ctrl  input  16  current instruction word from instruction memory.
MemReady  input  1  data memory has completed the current access.
Branch  output  1  branch-enable to datapath (datapath ANDs with Zero).
JumpControl  output  1  select Instr[9:0] as next PC.
MemRead  output  1  data memory read strobe.
MemWrite  output  1  data memory write strobe.
WriteControl  output  2  writeback select: 00 mem, 01 ALU, 10 Rs2, 11 ~Rs2.
ALUOperation  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
ALUSrc  output  1  1 = sign-extended Instr[9:0], 0 = Rs2.
RegWrite  output  1  register file write enable.
WndSelect  output  2  current register window.
PCWrite  output  1  PC register load enable.
Halted  output  1  sequencer in HALT.
Fault  output  1  sticky: memory timeout occurred.
RetireCount  output  CNT_W  instructions retired since reset.
State  output  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.

Behaviour:
- Reset (Rst=0 at posedge): State=FETCH, IR=0, WndSelect=00, RetireCount=0, Fault=0, timeout counter=0. All strobes 0. Rst overrides every state, including mid-MEM and HALT.
- Opcode decode on IR[15:12]:
  - 0000 LOAD: mem read, write back with WriteControl=00.
  - 0001 STORE: mem write.
  - 0010 JUMP.
  - 0011 HALT.
  - 0100 BEQ: SUB, ALUSrc=0, Branch.
  - 0111 NOP.
  - 1000 R-ALU: ALUOperation=IR[1:0], ALUSrc=0, WriteControl=01.
  - 1001 MOV: WriteControl=10.
  - 1010 NOT: WriteControl=11.
  - 1011 WND: WndSelect<=IR[1:0].
  - 11xx I-ALU: ALUOperation=IR[13:12], ALUSrc=1, WriteControl=01.
  - Any other opcode executes as NOP.
- FETCH (1 cycle): IR<=Instr2ctrl; next DECODE.
- DECODE (1 cycle): no strobes; next EXEC. Exceptions: LOAD/STORE go to MEM; HALT goes to HALT.
- EXEC (1 cycle): drive the decoded controls. RegWrite=1 for R-ALU, I-ALU, MOV, NOT. Branch=1 for BEQ; JumpControl=1 for JUMP. PCWrite=1 for every opcode. WND updates WndSelect at this edge. RetireCount+1. Next FETCH.
- MEM: MemRead (LOAD) or MemWrite (STORE) held high every cycle until the MemReady cycle inclusive.
  - In the cycle MemReady=1: LOAD also asserts RegWrite=1 with WriteControl=00; PCWrite=1; RetireCount+1; next FETCH.
  - The timeout counter increments on each cycle with MemReady=0. When it reaches MEM_TIMEOUT: Fault<=1, strobes drop, next HALT, no retire, no PCWrite.
  - The counter clears on MEM entry.
- HALT: all strobes 0, Halted=1. Leaves only via reset. The HALT opcode does not increment RetireCount.
- Latency: ALU/move/branch/jump/NOP/WND take 3 cycles per instruction. LOAD/STORE take 2 + (cycles until MemReady, min 1).
- Strobe rules:
  - At most one of MemRead/MemWrite is high at a time.
  - RegWrite and PCWrite are high for exactly one cycle per retired instruction.
  - Outputs are decoded only from the registered State and IR (Moore), never from Instr2ctrl directly.
- Control outputs outside EXEC/MEM: ALUSrc, ALUOperation and WriteControl=00; Branch, JumpControl, MemRead, MemWrite, RegWrite, PCWrite=0.
- RetireCount wraps from all-ones to 0 silently.
- MemReady outside MEM is ignored.

Test Plan:
- Reset then I-ALU 0xC005 (ADD imm 5) -> FETCH/DECODE/EXEC in 3 cycles. In EXEC: ALUSrc=1, ALUOperation=00, WriteControl=01, RegWrite=1, PCWrite=1 for one cycle. RetireCount=1.
- LOAD with MemReady low 3 cycles then high -> MemRead high 4 consecutive cycles. RegWrite+PCWrite only in the 4th, WriteControl=00. Total 6 cycles.
- STORE with MemReady never high, MEM_TIMEOUT=16 -> MemWrite high 16 cycles, then State=HALT, Fault=1, Halted=1, no PCWrite, RetireCount unchanged.
- WND 0xB002 then BEQ -> WndSelect changes 00->10 at the EXEC edge. BEQ EXEC: Branch=1, ALUOperation=01, ALUSrc=0.
- Opcode 0011 -> HALT after DECODE, all strobes 0. Assert Rst=0 one cycle -> FETCH, RetireCount=0, WndSelect=00.
- Rst=0 during MEM with MemRead high -> next cycle MemRead=0, State=FETCH, Fault=0.
